// File: rtl/trigger_rx_fsm.sv
// trigger_rx_fsm: receive end of the serial power-supply trigger link.
// Decodes 8N1 frames from rx and pulses trigger_out on TRIGGER_CODE.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   rx                        serial line, async to clk, idles high
//   data_out / data_valid     last good byte / 1-cycle update pulse
//   trigger_out               1-cycle pulse, byte == TRIGGER_CODE
//   frame_error               1-cycle pulse, stop bit sampled low
//   busy                      state != IDLE
//   trig_count                triggers received, wraps to 0
module trigger_rx_fsm #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  TRIGGER_CODE = 8'hA5,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             trigger_out,
  output logic             frame_error,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count
);

  localparam int CCW = $clog2(CLKS_PER_BIT);
  localparam logic [CCW-1:0] LAST = CCW'(CLKS_PER_BIT - 1);
  localparam logic [CCW-1:0] MID  = CCW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    START   = 5'b00010,
    DATA    = 5'b00100,
    STOP    = 5'b01000,
    WAIT_HI = 5'b10000
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CCW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             trig_q, trig_d;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    trig_d     = 1'b0;
    ferr_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == MID) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // a start bit gone high by mid-bit is a glitch
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CCW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CCW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
            if (shreg_q == TRIGGER_CODE) begin
              trig_d = 1'b1;
              cnt_d  = cnt_q + CNT_W'(1);
            end
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            // hold off until the line returns high (break)
            state_d = WAIT_HI;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CCW'(1);
        end
      end
      WAIT_HI: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      trig_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      trig_q     <= trig_d;
      ferr_q     <= ferr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign trigger_out = trig_q;
  assign frame_error = ferr_q;
  assign trig_count  = cnt_q;
  assign busy        = (state_q != IDLE);

endmodule
